// File: rtl/alarm_bank_if.sv
// alarm_bank_if: time, write-port, button and ring-status signals of the alarm bank
interface alarm_bank_if #(
  parameter int N_ALARM = 4
);
  localparam int IW = ($clog2(N_ALARM) > 1) ? $clog2(N_ALARM) : 1;
  logic               tick_1hz;
  logic [4:0]         hour;
  logic [5:0]         minute;
  logic [5:0]         second;
  logic [2:0]         week;
  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  logic [4:0]         wr_hour;
  logic [5:0]         wr_min;
  logic [6:0]         wr_days;
  logic               wr_on;
  logic               snooze;
  logic               dismiss;
  logic               ring;
  logic [IW-1:0]      ring_idx;
  logic               snoozing;
  logic [N_ALARM-1:0] on_mask;
  modport master (
    output tick_1hz, hour, minute, second, week, wr_en, wr_idx, wr_hour, wr_min,
           wr_days, wr_on, snooze, dismiss,
    input  ring, ring_idx, snoozing, on_mask
  );
  modport slave (
    input  tick_1hz, hour, minute, second, week, wr_en, wr_idx, wr_hour, wr_min,
           wr_days, wr_on, snooze, dismiss,
    output ring, ring_idx, snoozing, on_mask
  );
endinterface

// File: rtl/alarm_bank.sv
// alarm_bank: N-slot weekly alarm clock with ring timeout, limited snooze and one-shot slots
module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input logic        clk,
  input logic        rst,
  alarm_bank_if.slave bus
);
  localparam int IW   = ($clog2(N_ALARM) > 1) ? $clog2(N_ALARM) : 1;
  localparam int SNZ  = SNOOZE_MIN * 60;
  localparam int MAXC = (RING_SEC > SNZ) ? RING_SEC : SNZ;
  localparam int CW   = ($clog2(MAXC + 1) > 1) ? $clog2(MAXC + 1) : 1;
  localparam int SW   = ($clog2(MAX_SNOOZE + 1) > 1) ? $clog2(MAX_SNOOZE + 1) : 1;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
  state_t             r_state, w_next;
  logic [4:0]         r_hour [N_ALARM];
  logic [5:0]         r_min  [N_ALARM];
  logic [6:0]         r_days [N_ALARM];
  logic [N_ALARM-1:0] r_on;
  logic [CW-1:0]      r_cnt;
  logic [SW-1:0]      r_snz;
  logic [IW-1:0]      r_idx;
  logic [N_ALARM-1:0] w_match;
  logic [IW-1:0]      w_first;
  logic               w_fire;
  logic               w_wr;
  // per-slot match, only meaningful on the second tick
  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_ALARM; i++)
      w_match[i] = bus.tick_1hz && r_on[i] && r_hour[i] == bus.hour && r_min[i] == bus.minute &&
                   bus.second == 6'd0 && (r_days[i] == 7'd0 || |(r_days[i] & (7'd1 << bus.week)));
  end
  // lowest matching index wins
  always_comb begin
    w_first = '0;
    for (int i = N_ALARM - 1; i >= 0; i--)
      if (w_match[i]) w_first = IW'(i);
  end
  assign w_fire = r_state == IDLE && |w_match;
  assign w_wr   = bus.wr_en && bus.wr_hour <= 5'd23 && bus.wr_min <= 6'd59;
  // slot storage; a one-shot slot disarms itself as it fires, a later write in the same clk wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_on <= '0;
      for (int i = 0; i < N_ALARM; i++) begin
        r_hour[i] <= '0;
        r_min[i]  <= '0;
        r_days[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (w_fire && w_first == IW'(i) && r_days[i] == 7'd0) r_on[i] <= 1'b0;
        if (w_wr && bus.wr_idx == IW'(i)) begin
          r_hour[i] <= bus.wr_hour;
          r_min[i]  <= bus.wr_min;
          r_days[i] <= bus.wr_days;
          r_on[i]   <= bus.wr_on;
        end
      end
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: dismiss beats snooze, snooze beats the countdown expiring
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fire ? RINGING : IDLE;
      RINGING: w_next = bus.dismiss ? IDLE :
                        (bus.snooze && r_snz < SW'(MAX_SNOOZE)) ? SNOOZED :
                        (bus.tick_1hz && r_cnt <= CW'(1)) ? IDLE : RINGING;
      SNOOZED: w_next = bus.dismiss ? IDLE :
                        (bus.tick_1hz && r_cnt <= CW'(1)) ? RINGING : SNOOZED;
      default: w_next = IDLE;
    endcase
  end
  // shared ring/snooze countdown, snooze count and latched ring slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_snz <= '0;
      r_idx <= '0;
    end else if (w_fire) begin
      r_cnt <= CW'(RING_SEC);
      r_snz <= '0;
      r_idx <= w_first;
    end else if (w_next == IDLE) begin
      r_cnt <= '0;
    end else if (r_state == RINGING && w_next == SNOOZED) begin
      r_cnt <= CW'(SNZ);
      r_snz <= r_snz + 1'b1;
    end else if (r_state == SNOOZED && w_next == RINGING) begin
      r_cnt <= CW'(RING_SEC);
    end else if (bus.tick_1hz) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
  // outputs decoded from registered state
  always_comb begin
    bus.ring     = r_state == RINGING;
    bus.snoozing = r_state == SNOOZED;
    bus.ring_idx = r_idx;
    bus.on_mask  = r_on;
  end
endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 SHALL have parameter N_ALARM, default 4, number of alarm slots (2..16).
REQ-002 SHALL have parameter RING_SEC, default 60, ring duration in seconds before auto-stop.
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze interval in minutes.
REQ-004 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per trigger.
REQ-005 SHALL define IW = max(1, clog2(N_ALARM)).
REQ-006 clk  in  1  single system clock; all logic on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 tick_1hz  in  1  one-clk pulse per second from the divider.
REQ-009 hour  in  5  current hour, 0..23.
REQ-010 minute  in  6  current minute, 0..59.
REQ-011 second  in  6  current second, 0..59.
REQ-012 week  in  3  current weekday, 0..6.
REQ-013 wr_en  in  1  one-clk write strobe for slot wr_idx.
REQ-014 wr_idx  in  IW  slot index; values >= N_ALARM are ignored.
REQ-015 wr_hour, wr_min  in  5, 6  alarm time; out-of-range values (hour>23, min>59) are ignored for the whole write.
REQ-016 wr_days  in  7  weekday mask; bit d = weekday d; 0 means one-shot.
REQ-017 wr_on  in  1  slot enable.
REQ-018 snooze, dismiss  in  1  one-clk button pulses, already debounced.
REQ-019 ring  out  1  high while ringing; drives the music block.
REQ-020 ring_idx  out  IW  slot that caused the current ring or snooze.
REQ-021 snoozing  out  1  high in SNOOZED state.
REQ-022 on_mask  out  N_ALARM  current enable bit of each slot.

Function
REQ-023 SHALL hold per slot: hour, minute, days mask, enable; written one clk after the wr_en edge.
REQ-024 Match for slot i SHALL be: enable, hour/minute equal, second==0, and (days==0 or days[week]==1); evaluated only on tick_1hz.
REQ-025 Multiple simultaneous matches SHALL resolve to the lowest index; the others are dropped.
REQ-026 FSM states SHALL be IDLE, RINGING and SNOOZED.
REQ-027 IDLE->RINGING on match: ring=1 the clk after the tick; ring_idx latched; ring counter loaded RING_SEC; snooze count cleared.
REQ-028 Matches in RINGING or SNOOZED SHALL be ignored.
REQ-029 A one-shot slot (days==0) SHALL clear its enable in the same clk it triggers.
REQ-030 RINGING: ring counter decrements on each tick_1hz; at reaching 0 -> IDLE.
REQ-031 RINGING + snooze with count < MAX_SNOOZE -> SNOOZED; count+1; snooze counter loaded SNOOZE_MIN*60.
REQ-032 Snooze at count == MAX_SNOOZE SHALL be ignored.
REQ-033 SNOOZED: counter decrements on tick; at 0 -> RINGING with ring counter reloaded RING_SEC.
REQ-034 dismiss in RINGING or SNOOZED -> IDLE next clk; dismiss and snooze in the same clk: dismiss wins.
REQ-035 snooze or dismiss in IDLE SHALL have no effect.
REQ-036 Writing a slot during RINGING/SNOOZED SHALL update storage only; the current ring sequence is unaffected, including for the same slot.
REQ-037 Counters SHALL be wide enough for max(RING_SEC, SNOOZE_MIN*60) without wrap.

Reset
REQ-038 On rst: state IDLE, ring=0, snoozing=0, ring_idx=0, counters=0, snooze count=0.
REQ-039 On rst: all slots time 00:00, days 0, enable 0; on_mask=0.
REQ-040 rst SHALL take priority over every other input in the same clk, including mid-ring.

Verification
REQ-041 Slot1 07:30 days=0x7F on: tick at 07:30:00 -> ring=1, ring_idx=1 next clk; 60 ticks later ring=0.
REQ-042 Slots 0 and 2 both 06:00 on: tick at 06:00:00 -> ring_idx=0; slot 2 not rung.
REQ-043 Ring, then snooze x3 with 300 ticks between re-rings -> ring returns each time; 4th snooze ignored; ring stays 1.
REQ-044 One-shot slot 3 at 12:00, days=0 -> rings once; on_mask[3]=0; same time next day -> no ring.
REQ-045 snooze and dismiss in the same clk while ringing -> IDLE, snoozing=0; rst mid-SNOOZED -> all outputs 0 next clk.
REQ-046 days=0x02 with week=3 at a matching time -> no ring; wr_hour=24 write -> slot unchanged.
